// File: rtl/shft_pkg.sv
// Shared types and constants for the load-and-shift sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shft_pkg;

  // Width of the parallel word; the downstream register is fixed at 4 bits.
  localparam int W = 4;

  // Largest shift count honoured; larger requests are clamped to this.
  localparam logic [2:0] MAX_SH = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    FIN   = 3'd3,
    CLR   = 3'd4
  } state_t;

  // Clamp a requested shift count to the register depth.
  function automatic logic [2:0] sat_nsh(input logic [2:0] n);
    return (n > MAX_SH) ? MAX_SH : n;
  endfunction

endpackage

// File: rtl/shft_seq_ctrl_if.sv
// Request/control bundle between a sequence requester and shft_seq_ctrl.
// Latency: n/a (wires only).
// Backpressure: requester may only start when ready is high; start otherwise dropped.
interface shft_seq_ctrl_if #(
  parameter int W = 4
);

  // Requester side
  logic         start;
  logic         abort;
  logic [W-1:0] word;
  logic [W-1:0] sword;
  logic [2:0]   nsh;

  // Controls towards the downstream register plus status
  logic         ld;
  logic         shft;
  logic         clr_n;
  logic [W-1:0] inp;
  logic         ins;
  logic         ready;
  logic         done;
  logic [W-1:0] mirror;

  modport master (
    output start, abort, word, sword, nsh,
    input  ld, shft, clr_n, inp, ins, ready, done, mirror
  );

  modport slave (
    input  start, abort, word, sword, nsh,
    output ld, shft, clr_n, inp, ins, ready, done, mirror
  );

endinterface

// File: rtl/shft_cnt.sv
// Loadable 3-bit down-counter with zero flag, paces the shift phase.
// Latency: load/decrement visible one cycle after the request edge.
// Backpressure: none; clear beats load beats decrement.
module shft_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ld,
  input  logic [2:0] ld_val,
  input  logic       dec,
  output logic [2:0] cnt,
  output logic       zero
);

  logic [2:0] cnt_q;

  // Count register: reset/clear to zero, else load, else count down.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= 3'd0;
    end else if (ld) begin
      cnt_q <= ld_val;
    end else if (dec) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/shft_seq_ctrl.sv
// Drives load/shift/clear of a negedge 4-bit register and mirrors its contents.
// Latency: start accepted in cycle 0 -> ld cycle 1 -> shft cycles 2..n+1 -> done n+2 -> ready n+3.
// Backpressure: start only accepted while ready=1; otherwise dropped, never queued.
module shft_seq_ctrl #(
  parameter int W = shft_pkg::W  // only 4 is supported
) (
  input  logic             clk,
  input  logic             rst,
  shft_seq_ctrl_if.slave   bus
);

  import shft_pkg::*;

  state_t       state_q;
  state_t       state_nxt;

  // Counter hookup
  logic         cnt_clr;
  logic         cnt_ld;
  logic         cnt_dec;
  logic [2:0]   cnt_ld_val;
  logic [2:0]   cnt;
  logic         cnt_zero;

  // Registered outputs; each is a function of the state being entered so
  // the downstream negedge sampler sees values stable for half a cycle.
  logic         ld_q;
  logic         shft_q;
  logic         clr_n_q;
  logic         done_q;
  logic         ready_q;
  logic [W-1:0] inp_q;
  logic         ins_q;
  logic [W-1:0] mirror_q;

  // Serial-in word, consumed LSB first; shifted right once per shift cycle.
  logic [W-1:0] sreg_q;

  shft_cnt u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .ld     (cnt_ld),
    .ld_val (cnt_ld_val),
    .dec    (cnt_dec),
    .cnt    (cnt),
    .zero   (cnt_zero)
  );

  // State register; reset parks in CLR so the first free cycle exits to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and counter control; abort overrides every state and start.
  always_comb begin
    state_nxt  = state_q;
    cnt_clr    = 1'b0;
    cnt_ld     = 1'b0;
    cnt_dec    = 1'b0;
    cnt_ld_val = sat_nsh(bus.nsh);
    if (bus.abort) begin
      state_nxt = CLR;
      cnt_clr   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_nxt = LOAD;
            cnt_ld    = 1'b1;
          end
        end
        LOAD: begin
          state_nxt = cnt_zero ? FIN : SHIFT;
        end
        SHIFT: begin
          cnt_dec = 1'b1;
          // Last shift is the one issued while the count reads 1; the <=
          // also guarantees an exit should the count ever read 0 here.
          if (cnt <= 3'd1) begin
            state_nxt = FIN;
          end
        end
        FIN: begin
          state_nxt = IDLE;
        end
        CLR: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = CLR;
        end
      endcase
    end
  end

  // Output/data registers, driven from the state about to be entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q     <= 1'b0;
      shft_q   <= 1'b0;
      clr_n_q  <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      inp_q    <= '0;
      ins_q    <= 1'b0;
      mirror_q <= '0;
      sreg_q   <= '0;
    end else begin
      ld_q    <= (state_nxt == LOAD);
      shft_q  <= (state_nxt == SHIFT);
      clr_n_q <= (state_nxt != CLR);
      done_q  <= (state_nxt == FIN);
      ready_q <= (state_nxt == IDLE);
      ins_q   <= 1'b0;
      case (state_nxt)
        LOAD: begin
          // Only reachable from an accepted start: capture the request here.
          inp_q    <= bus.word;
          mirror_q <= bus.word;
          sreg_q   <= bus.sword;
        end
        SHIFT: begin
          ins_q    <= sreg_q[0];
          mirror_q <= {sreg_q[0], mirror_q[W-1:1]};
          sreg_q   <= {1'b0, sreg_q[W-1:1]};
        end
        CLR: begin
          mirror_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ld     = ld_q;
  assign bus.shft   = shft_q;
  assign bus.clr_n  = clr_n_q;
  assign bus.done   = done_q;
  assign bus.ready  = ready_q;
  assign bus.inp    = inp_q;
  assign bus.ins    = ins_q;
  assign bus.mirror = mirror_q;

endmodule

// File: tb/tb_shft_seq_ctrl.sv
// Directed plus random stimulus for shft_seq_ctrl against a cycle-count reference.
// Latency: reference predicts outputs the edge after each set of inputs.
// Backpressure: start applied freely; reference drops it unless idle.
module tb_shft_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shft_seq_ctrl_if #(.W(4)) bus ();

  shft_seq_ctrl #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  string phase = "reset";

  // Reference: a sequence is described by its phase number since acceptance
  // (1 = load, 2..n+1 = shifts, n+2 = done), straight from the latency rule.
  typedef enum {M_CLR, M_IDLE, M_RUN} mmode_t;
  mmode_t     m_mode = M_CLR;
  int         m_ph = 0;
  int         m_n = 0;
  logic [3:0] m_sword = 4'd0;
  logic [3:0] m_inp = 4'd0;
  logic [3:0] m_mirror = 4'd0;

  logic       e_ld, e_shft, e_ins, e_done, e_ready, e_clr_n;

  int n_ld, n_shft, n_done, n_clr;

  function automatic int sat(input int n);
    return (n > 4) ? 4 : n;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  // Advance the reference by one rising edge using the inputs now applied.
  task automatic model_edge();
    int bitv;
    if (rst) begin
      m_mode   = M_CLR;
      m_mirror = 4'd0;
      m_inp    = 4'd0;
    end else if (bus.abort) begin
      m_mode   = M_CLR;
      m_mirror = 4'd0;
    end else begin
      case (m_mode)
        M_CLR: m_mode = M_IDLE;
        M_IDLE: begin
          if (bus.start) begin
            m_mode   = M_RUN;
            m_ph     = 1;
            m_n      = sat(int'(bus.nsh));
            m_sword  = bus.sword;
            m_inp    = bus.word;
            m_mirror = bus.word;
          end
        end
        default: begin
          if (m_ph == m_n + 2) begin
            m_mode = M_IDLE;
          end else begin
            m_ph++;
            if (m_ph <= m_n + 1) begin
              bitv     = int'(m_sword[m_ph-2]);
              m_mirror = 4'((int'(m_mirror) >> 1) + bitv * 8);
            end
          end
        end
      endcase
    end
    e_ld    = (m_mode == M_RUN) && (m_ph == 1);
    e_shft  = (m_mode == M_RUN) && (m_ph >= 2) && (m_ph <= m_n + 1);
    e_ins   = 1'b0;
    if (e_shft) e_ins = m_sword[m_ph-2];
    e_done  = (m_mode == M_RUN) && (m_ph == m_n + 2);
    e_ready = (m_mode == M_IDLE);
    e_clr_n = (m_mode != M_CLR);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("ld",     8'(bus.ld),     8'(e_ld));
    chk("shft",   8'(bus.shft),   8'(e_shft));
    chk("clr_n",  8'(bus.clr_n),  8'(e_clr_n));
    chk("done",   8'(bus.done),   8'(e_done));
    chk("ready",  8'(bus.ready),  8'(e_ready));
    chk("ins",    8'(bus.ins),    8'(e_ins));
    chk("inp",    8'(bus.inp),    8'(m_inp));
    chk("mirror", 8'(bus.mirror), 8'(m_mirror));
    chk("ld_shft_excl", 8'(bus.ld & bus.shft), 8'd0);
    n_ld   += int'(bus.ld);
    n_shft += int'(bus.shft);
    n_done += int'(bus.done);
    n_clr  += int'(!bus.clr_n);
  endtask

  task automatic drive(input logic s, input logic a, input logic [3:0] w,
                       input logic [3:0] sw, input logic [2:0] n);
    bus.start = s;
    bus.abort = a;
    bus.word  = w;
    bus.sword = sw;
    bus.nsh   = n;
  endtask

  task automatic clr_counts();
    n_ld = 0; n_shft = 0; n_done = 0; n_clr = 0;
  endtask

  // One start pulse followed by a quiet tail.
  task automatic run_seq(input logic [3:0] w, input logic [3:0] sw,
                         input logic [2:0] n, input int tail);
    drive(1'b1, 1'b0, w, sw, n);
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    for (int i = 0; i < tail; i++) tick();
  endtask

  initial begin
    clr_counts();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);

    // Reset with start and abort both active: reset wins.
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'hf, 4'hf, 3'd4);
    tick();
    tick();
    chk("rst_ready", 8'(bus.ready), 8'd0);
    chk("rst_clr_n", 8'(bus.clr_n), 8'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    tick();
    chk("post_rst_ready", 8'(bus.ready), 8'd1);

    phase = "full";
    clr_counts();
    run_seq(4'b1010, 4'b0110, 3'd4, 7);
    chk("mirror_final", 8'(bus.mirror), 8'b0110);
    chk("n_shft", 8'(n_shft), 8'd4);
    chk("n_done", 8'(n_done), 8'd1);

    phase = "load_only";
    clr_counts();
    run_seq(4'b1111, 4'b0101, 3'd0, 4);
    chk("mirror_final", 8'(bus.mirror), 8'b1111);
    chk("n_shft", 8'(n_shft), 8'd0);
    chk("n_ld", 8'(n_ld), 8'd1);

    phase = "saturate";
    clr_counts();
    run_seq(4'b0001, 4'b1000, 3'd7, 8);
    chk("mirror_final", 8'(bus.mirror), 8'b1000);
    chk("n_shft", 8'(n_shft), 8'd4);

    phase = "mid_abort";
    clr_counts();
    run_seq(4'b1100, 4'b1011, 3'd4, 2);
    drive(1'b0, 1'b1, 4'd0, 4'd0, 3'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("n_shft", 8'(n_shft), 8'd2);
    chk("n_done", 8'(n_done), 8'd0);
    chk("n_clr", 8'(n_clr), 8'd1);
    chk("mirror_final", 8'(bus.mirror), 8'd0);

    phase = "busy_start";
    clr_counts();
    drive(1'b1, 1'b0, 4'b0011, 4'b0101, 3'd3);
    for (int i = 0; i < 7; i++) tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("n_ld", 8'(n_ld), 8'd2);

    phase = "rst_mid";
    clr_counts();
    run_seq(4'b0110, 4'b1001, 3'd4, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("n_done", 8'(n_done), 8'd0);

    phase = "abort_start";
    clr_counts();
    drive(1'b1, 1'b1, 4'b1110, 4'b0001, 3'd2);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    for (int i = 0; i < 2; i++) tick();
    chk("n_ld", 8'(n_ld), 8'd0);
    chk("n_clr", 8'(n_clr), 8'd3);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
            4'($urandom), 4'($urandom), 3'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
